// File: rtl/qrd_input_scheduler.sv
// qrd_input_scheduler: buffers one 4x5 complex [H|y] block, replays it as skewed
// row feeds for the QRD core. Define QRD_SCHED_DBUF_EN for a second buffer bank.
module qrd_input_scheduler #(
  parameter int DW        = 14,
  parameter int ROW3_OFS  = 21,
  parameter int ROW4_OFS  = 41,
  parameter int FRAME_LEN = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data_r,
  input  logic [DW-1:0] s_data_i,
  input  logic          qrd_in_ready,
  output logic [DW-1:0] row_in_1_r,
  output logic [DW-1:0] row_in_1_i,
  output logic [DW-1:0] row_in_2_r,
  output logic [DW-1:0] row_in_2_i,
  output logic [DW-1:0] row_in_3_r,
  output logic [DW-1:0] row_in_3_i,
  output logic [DW-1:0] row_in_4_r,
  output logic [DW-1:0] row_in_4_i,
  output logic          row_in_1_f,
  output logic          row_in_2_f,
  output logic          row_in_3_f,
  output logic          busy,
  output logic          frame_done
);
  localparam int NS = 20;
`ifdef QRD_SCHED_DBUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int AW = $clog2(NB * NS);
  localparam int TW = $clog2(FRAME_LEN);
  localparam logic [TW-1:0] T_LAST = TW'(FRAME_LEN - 1);
  localparam int OFS [4] = '{0, 1, ROW3_OFS, ROW4_OFS};

  typedef enum logic [1:0] {LOAD, WAIT, ISSUE} state_t;

  state_t          state_q, state_d;
  logic [4:0]      fill_q, fill_d;
  logic [TW-1:0]   t_q, t_d;
  logic            s_ready_q, s_ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [2:0]      flag_q, flag_d;
  logic [2*DW-1:0] row_q [4];
  logic [2*DW-1:0] row_d [4];
  logic [2*DW-1:0] mem_q [NB*NS];
  logic            we, hs;
  logic [AW-1:0]   waddr, rbase;
`ifdef QRD_SCHED_DBUF_EN
  logic [1:0]      full_q, full_d;
  logic            wr_q, wr_d, rd_q, rd_d;
`endif

  assign hs = s_valid && s_ready_q;

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    t_d       = t_q;
    s_ready_d = 1'b0;
    done_d    = 1'b0;
    we        = 1'b0;
`ifdef QRD_SCHED_DBUF_EN
    full_d = full_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    waddr  = (wr_q ? AW'(NS) : '0) + AW'(fill_q);
    rbase  = rd_q ? AW'(NS) : '0;
    if (hs) begin
      we = 1'b1;
      if (fill_q == 5'(NS - 1)) begin
        fill_d       = '0;
        full_d[wr_q] = 1'b1;
        wr_d         = ~wr_q;
      end else begin
        fill_d = fill_q + 5'd1;
      end
    end
    unique case (state_q)
      LOAD: if (full_d[rd_q]) state_d = WAIT;
      WAIT: if (qrd_in_ready) begin
        state_d = ISSUE;
        t_d     = '0;
      end
      ISSUE: begin
        t_d = t_q + TW'(1);
        if (t_q == T_LAST) begin
          done_d       = 1'b1;
          t_d          = '0;
          full_d[rd_q] = 1'b0;
          rd_d         = ~rd_q;
          // stay in ISSUE for a back-to-back frame from the other bank
          if (!full_d[~rd_q]) state_d = LOAD;
          else if (!qrd_in_ready) state_d = WAIT;
        end
      end
      default: state_d = LOAD;
    endcase
    s_ready_d = !full_d[wr_d];
`else
    waddr = AW'(fill_q);
    rbase = '0;
    unique case (state_q)
      LOAD: begin
        s_ready_d = 1'b1;
        if (hs) begin
          we     = 1'b1;
          fill_d = fill_q + 5'd1;
          if (fill_q == 5'(NS - 1)) begin
            state_d   = WAIT;
            s_ready_d = 1'b0;
          end
        end
      end
      WAIT: if (qrd_in_ready) begin
        state_d = ISSUE;
        t_d     = '0;
      end
      ISSUE: begin
        t_d = t_q + TW'(1);
        if (t_q == T_LAST) begin
          done_d    = 1'b1;
          fill_d    = '0;
          t_d       = '0;
          state_d   = LOAD;
          s_ready_d = 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
`endif
    busy_d = (state_d != LOAD);
  end

  always_comb begin
    int e;
    e      = 0;
    flag_d = '0;
    for (int k = 0; k < 4; k++) row_d[k] = '0;
    if (state_q == ISSUE) begin
      for (int k = 0; k < 4; k++) begin
        e = int'(t_q) - OFS[k];
        if (e >= 0 && e < 5) row_d[k] = mem_q[rbase + AW'(5 * k + e)];
      end
      flag_d[0] = (t_q == '0);
      flag_d[1] = (t_q == TW'(2));
      flag_d[2] = (t_q == TW'(ROW3_OFS + 2));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LOAD;
      fill_q    <= '0;
      t_q       <= '0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      flag_q    <= '0;
      for (int k = 0; k < 4; k++) row_q[k] <= '0;
`ifdef QRD_SCHED_DBUF_EN
      full_q <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      t_q       <= t_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      flag_q    <= flag_d;
      for (int k = 0; k < 4; k++) row_q[k] <= row_d[k];
`ifdef QRD_SCHED_DBUF_EN
      full_q <= full_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= {s_data_r, s_data_i};
  end

  assign s_ready    = s_ready_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign row_in_1_f = flag_q[0];
  assign row_in_2_f = flag_q[1];
  assign row_in_3_f = flag_q[2];
  assign row_in_1_r = row_q[0][2*DW-1:DW];
  assign row_in_1_i = row_q[0][DW-1:0];
  assign row_in_2_r = row_q[1][2*DW-1:DW];
  assign row_in_2_i = row_q[1][DW-1:0];
  assign row_in_3_r = row_q[2][2*DW-1:DW];
  assign row_in_3_i = row_q[2][DW-1:0];
  assign row_in_4_r = row_q[3][2*DW-1:DW];
  assign row_in_4_i = row_q[3][DW-1:0];
endmodule
